mii_rx_sequencer: RTL and testbench

MII_RX_SEQUENCER -- requirements
Module: mii_rx_sequencer

---
 rtl/mii_rx_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_mii_rx_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mii_rx_sequencer.sv
// MII receive sequencer: preamble/SFD search, nibble-to-byte assembly,
// one-byte hold for tlast marking, error and length policing.
module mii_rx_sequencer #(
  parameter int MIN_PREAMBLE    = 2,
  parameter int MAX_FRAME_BYTES = 1522
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] mii_rxd,
  input  logic       mii_rx_dv,
  input  logic       mii_rx_er,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       status_frame_good,
  output logic       status_frame_bad,
  output logic       status_bad_sfd
);

  localparam int PW = $clog2(MIN_PREAMBLE + 2);
  localparam int CL = $clog2(MAX_FRAME_BYTES + 1);
  localparam int CW = (CL > 11) ? CL : 11;
  localparam logic [PW-1:0] PRE_MIN = PW'(MIN_PREAMBLE);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_FRAME_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    LOW_NIB,
    HIGH_NIB,
    DROP
  } state_t;

  state_t        r_state;
  state_t        w_state;
  logic [PW-1:0] r_pre_cnt;
  logic [PW-1:0] w_pre_cnt;
  logic [3:0]    r_lo;
  logic [3:0]    w_lo;
  logic [7:0]    r_hold;
  logic [7:0]    w_hold;
  logic          r_held;
  logic          w_held;
  logic          r_err;
  logic          w_err;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;

  logic          r_tvalid;
  logic          w_tvalid;
  logic [7:0]    r_tdata;
  logic [7:0]    w_tdata;
  logic          r_tlast;
  logic          w_tlast;
  logic          r_tuser;
  logic          w_tuser;
  logic          r_good;
  logic          w_good;
  logic          r_bad;
  logic          w_bad;
  logic          r_sfd;
  logic          w_sfd;

  logic [7:0]    w_byte;
  logic          w_err_now;

  assign w_byte    = {mii_rxd, r_lo};
  assign w_err_now = r_err | mii_rx_er;

  always_comb begin
    w_state   = r_state;
    w_pre_cnt = r_pre_cnt;
    w_lo      = r_lo;
    w_hold    = r_hold;
    w_held    = r_held;
    w_err     = r_err;
    w_cnt     = r_cnt;
    w_tvalid  = 1'b0;
    w_tdata   = 8'h00;
    w_tlast   = 1'b0;
    w_tuser   = 1'b0;
    w_good    = 1'b0;
    w_bad     = 1'b0;
    w_sfd     = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_pre_cnt = '0;
        w_held    = 1'b0;
        w_err     = 1'b0;
        w_cnt     = '0;
        if (mii_rx_dv) begin
          if (mii_rxd == 4'h5) begin
            w_state   = PREAMBLE;
            w_pre_cnt = PW'(1);
          end else begin
            w_state = DROP;
            w_sfd   = 1'b1;
          end
        end
      end

      PREAMBLE: begin
        if (!mii_rx_dv) begin
          w_state = IDLE;
        end else if (mii_rxd == 4'h5) begin
          if (r_pre_cnt < PRE_MIN)
            w_pre_cnt = r_pre_cnt + PW'(1);
        end else if (mii_rxd == 4'hD &&
                     r_pre_cnt >= PRE_MIN) begin
          w_state = LOW_NIB;
        end else begin
          w_state = DROP;
          w_sfd   = 1'b1;
        end
      end

      LOW_NIB: begin
        if (mii_rx_dv) begin
          w_lo    = mii_rxd;
          w_err   = w_err_now;
          w_state = HIGH_NIB;
        end else begin
          // frame ended on a byte boundary
          w_state = IDLE;
          if (r_held) begin
            w_tvalid = 1'b1;
            w_tdata  = r_hold;
            w_tlast  = 1'b1;
            w_tuser  = r_err;
            w_good   = !r_err;
            w_bad    = r_err;
          end else begin
            w_bad = 1'b1;
          end
          w_held = 1'b0;
          w_err  = 1'b0;
          w_cnt  = '0;
        end
      end

      HIGH_NIB: begin
        if (mii_rx_dv && r_cnt == CNT_MAX) begin
          // oversize: close frame on the held byte
          w_state  = DROP;
          w_tvalid = r_held;
          w_tdata  = r_held ? r_hold : 8'h00;
          w_tlast  = r_held;
          w_tuser  = r_held;
          w_bad    = 1'b1;
          w_held   = 1'b0;
          w_err    = 1'b0;
          w_cnt    = '0;
        end else if (mii_rx_dv) begin
          w_state  = LOW_NIB;
          w_tvalid = r_held;
          w_tdata  = r_held ? r_hold : 8'h00;
          w_hold   = w_byte;
          w_held   = 1'b1;
          w_err    = w_err_now;
          w_cnt    = r_cnt + CW'(1);
        end else begin
          // odd nibble: partial byte dropped
          w_state  = IDLE;
          w_tvalid = r_held;
          w_tdata  = r_held ? r_hold : 8'h00;
          w_tlast  = r_held;
          w_tuser  = r_held;
          w_bad    = 1'b1;
          w_held   = 1'b0;
          w_err    = 1'b0;
          w_cnt    = '0;
        end
      end

      DROP: begin
        w_held = 1'b0;
        w_err  = 1'b0;
        w_cnt  = '0;
        if (!mii_rx_dv)
          w_state = IDLE;
      end

      default: begin
        w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pre_cnt <= '0;
      r_lo      <= 4'h0;
      r_hold    <= 8'h00;
      r_held    <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_tvalid  <= 1'b0;
      r_tdata   <= 8'h00;
      r_tlast   <= 1'b0;
      r_tuser   <= 1'b0;
      r_good    <= 1'b0;
      r_bad     <= 1'b0;
      r_sfd     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_pre_cnt <= w_pre_cnt;
      r_lo      <= w_lo;
      r_hold    <= w_hold;
      r_held    <= w_held;
      r_err     <= w_err;
      r_cnt     <= w_cnt;
      r_tvalid  <= w_tvalid;
      r_tdata   <= w_tdata;
      r_tlast   <= w_tlast;
      r_tuser   <= w_tuser;
      r_good    <= w_good;
      r_bad     <= w_bad;
      r_sfd     <= w_sfd;
    end
  end

  assign m_axis_tvalid     = r_tvalid;
  assign m_axis_tdata      = r_tdata;
  assign m_axis_tlast      = r_tlast;
  assign m_axis_tuser      = r_tuser;
  assign status_frame_good = r_good;
  assign status_frame_bad  = r_bad;
  assign status_bad_sfd    = r_sfd;

endmodule

// File: tb/tb_mii_rx_sequencer.sv
// Table-driven bench for mii_rx_sequencer: default instance plus a
// MAX_FRAME_BYTES=4 instance for truncation.
module tb_mii_rx_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [3:0] rxd = 4'h0;
  logic       dv  = 1'b0;
  logic       er  = 1'b0;

  logic [7:0] a_td;
  logic       a_tv, a_tl, a_tu, a_g, a_b, a_s;
  logic [7:0] b_td;
  logic       b_tv, b_tl, b_tu, b_g, b_b, b_s;

  mii_rx_sequencer u_dut (
    .clk(clk), .rst(rst),
    .mii_rxd(rxd), .mii_rx_dv(dv), .mii_rx_er(er),
    .m_axis_tdata(a_td), .m_axis_tvalid(a_tv),
    .m_axis_tlast(a_tl), .m_axis_tuser(a_tu),
    .status_frame_good(a_g), .status_frame_bad(a_b),
    .status_bad_sfd(a_s)
  );

  mii_rx_sequencer #(.MAX_FRAME_BYTES(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .mii_rxd(rxd), .mii_rx_dv(dv), .mii_rx_er(er),
    .m_axis_tdata(b_td), .m_axis_tvalid(b_tv),
    .m_axis_tlast(b_tl), .m_axis_tuser(b_tu),
    .status_frame_good(b_g), .status_frame_bad(b_b),
    .status_bad_sfd(b_s)
  );

  typedef struct packed {
    logic       tv;
    logic [7:0] td;
    logic       tl;
    logic       tu;
    logic       g;
    logic       b;
    logic       s;
  } out_t;

  typedef struct {
    logic       r;
    logic       dv;
    logic [3:0] d;
    logic       er;
    out_t       o;
  } vec_t;

  localparam out_t Z = '0;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic out_t B(input logic [7:0] d, input logic l,
                             input logic u, input logic g,
                             input logic b);
    return {1'b1, d, l, u, g, b, 1'b0};
  endfunction

  function automatic out_t S(input logic g, input logic b,
                             input logic s);
    return {1'b0, 8'h00, 1'b0, 1'b0, g, b, s};
  endfunction

  function automatic void add(input logic r, input logic v,
                              input logic [3:0] d, input logic e,
                              input out_t o);
    vec_t x;
    x.r = r; x.dv = v; x.d = d; x.er = e; x.o = o;
    tbl.push_back(x);
  endfunction

  function automatic void pre(input int n);
    for (int i = 0; i < n; i++) add(0, 1, 4'h5, 0, Z);
    add(0, 1, 4'hD, 0, Z);
  endfunction

  task automatic run(input int sel, input string nm);
    out_t act;
    foreach (tbl[i]) begin
      rst = tbl[i].r;
      dv  = tbl[i].dv;
      rxd = tbl[i].d;
      er  = tbl[i].er;
      @(posedge clk);
      #1;
      if (sel == 0)
        act = {a_tv, a_td, a_tl, a_tu, a_g, a_b, a_s};
      else
        act = {b_tv, b_td, b_tl, b_tu, b_g, b_b, b_s};
      n_cmp++;
      if (act !== tbl[i].o) begin
        n_bad++;
        $display("FAIL %s row %0d: got tv=%b d=%h l=%b u=%b g=%b b=%b s=%b want tv=%b d=%h l=%b u=%b g=%b b=%b s=%b",
                 nm, i, act.tv, act.td, act.tl, act.tu, act.g,
                 act.b, act.s, tbl[i].o.tv, tbl[i].o.td,
                 tbl[i].o.tl, tbl[i].o.tu, tbl[i].o.g,
                 tbl[i].o.b, tbl[i].o.s);
      end
    end
    tbl.delete();
  endtask

  initial begin
    // reset state
    add(1, 0, 4'h0, 0, Z);
    add(1, 0, 4'h0, 0, Z);
    add(0, 0, 4'h0, 0, Z);
    // good frame 01 02 03
    pre(7);
    add(0, 1, 4'h1, 0, Z);
    add(0, 1, 4'h0, 0, Z);
    add(0, 1, 4'h2, 0, Z);
    add(0, 1, 4'h0, 0, B(8'h01, 0, 0, 0, 0));
    add(0, 1, 4'h3, 0, Z);
    add(0, 1, 4'h0, 0, B(8'h02, 0, 0, 0, 0));
    add(0, 0, 4'h0, 0, B(8'h03, 1, 0, 1, 0));
    // back-to-back frame with rx_er on byte 02
    pre(7);
    add(0, 1, 4'h1, 0, Z);
    add(0, 1, 4'h0, 0, Z);
    add(0, 1, 4'h2, 1, Z);
    add(0, 1, 4'h0, 0, B(8'h01, 0, 0, 0, 0));
    add(0, 1, 4'h3, 0, Z);
    add(0, 1, 4'h0, 0, B(8'h02, 0, 0, 0, 0));
    add(0, 0, 4'h0, 0, B(8'h03, 1, 1, 0, 1));
    add(0, 0, 4'h0, 0, Z);
    // short preamble, then dropped until dv falls
    add(0, 1, 4'h5, 0, Z);
    add(0, 1, 4'hD, 0, S(0, 0, 1));
    add(0, 1, 4'h1, 0, Z);
    add(0, 1, 4'h5, 0, Z);
    add(0, 1, 4'hD, 0, Z);
    add(0, 0, 4'h0, 0, Z);
    // next frame A5 3C received normally
    pre(2);
    add(0, 1, 4'h5, 0, Z);
    add(0, 1, 4'hA, 0, Z);
    add(0, 1, 4'hC, 0, Z);
    add(0, 1, 4'h3, 0, B(8'hA5, 0, 0, 0, 0));
    add(0, 0, 4'h0, 0, B(8'h3C, 1, 0, 1, 0));
    // five nibbles: odd ending
    pre(2);
    add(0, 1, 4'h1, 0, Z);
    add(0, 1, 4'h0, 0, Z);
    add(0, 1, 4'h2, 0, Z);
    add(0, 1, 4'h0, 0, B(8'h01, 0, 0, 0, 0));
    add(0, 1, 4'h7, 0, Z);
    add(0, 0, 4'h0, 0, B(8'h02, 1, 1, 0, 1));
    // zero-byte frame
    pre(2);
    add(0, 0, 4'h0, 0, S(0, 1, 0));
    // dv falls inside preamble: silent
    add(0, 1, 4'h5, 0, Z);
    add(0, 0, 4'h0, 0, Z);
    // single odd nibble
    pre(2);
    add(0, 1, 4'h4, 0, Z);
    add(0, 0, 4'h0, 0, S(0, 1, 0));
    // non-preamble nibble from idle
    add(0, 1, 4'h3, 0, S(0, 0, 1));
    add(0, 1, 4'h5, 0, Z);
    add(0, 0, 4'h0, 0, Z);
    // reset mid-payload
    pre(2);
    add(0, 1, 4'h1, 0, Z);
    add(0, 1, 4'h0, 0, Z);
    add(0, 1, 4'h2, 0, Z);
    add(0, 1, 4'h0, 0, B(8'h01, 0, 0, 0, 0));
    add(1, 1, 4'h3, 0, Z);
    add(0, 1, 4'h0, 0, S(0, 0, 1));
    add(0, 1, 4'h4, 0, Z);
    add(0, 0, 4'h0, 0, Z);
    pre(2);
    add(0, 1, 4'h6, 0, Z);
    add(0, 1, 4'h6, 0, Z);
    add(0, 0, 4'h0, 0, B(8'h66, 1, 0, 1, 0));
    add(0, 0, 4'h0, 0, Z);
    run(0, "main");

    // truncation at MAX_FRAME_BYTES=4
    add(1, 0, 4'h0, 0, Z);
    add(0, 0, 4'h0, 0, Z);
    pre(2);
    add(0, 1, 4'h1, 0, Z);
    add(0, 1, 4'h1, 0, Z);
    add(0, 1, 4'h2, 0, Z);
    add(0, 1, 4'h2, 0, B(8'h11, 0, 0, 0, 0));
    add(0, 1, 4'h3, 0, Z);
    add(0, 1, 4'h3, 0, B(8'h22, 0, 0, 0, 0));
    add(0, 1, 4'h4, 0, Z);
    add(0, 1, 4'h4, 0, B(8'h33, 0, 0, 0, 0));
    add(0, 1, 4'h5, 0, Z);
    add(0, 1, 4'h5, 0, B(8'h44, 1, 1, 0, 1));
    add(0, 1, 4'h6, 0, Z);
    add(0, 1, 4'h6, 0, Z);
    add(0, 0, 4'h0, 0, Z);
    pre(2);
    add(0, 1, 4'h7, 0, Z);
    add(0, 1, 4'h7, 0, Z);
    add(0, 0, 4'h0, 0, B(8'h77, 1, 0, 1, 0));
    add(0, 0, 4'h0, 0, Z);
    run(1, "trunc");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
